// File: rtl/multi_key_beep_pkg.sv
// Shared definitions for the multi-key beeper: FSM state encoding and the
// counter-width helper used to size every down/up counter in the block.
package multi_key_beep_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StOn,
    StOff
  } beep_state_e;

  // Bits needed to hold values 0..max_count-1, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_count);
    int unsigned w;
    w = $clog2(max_count);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/multi_key_beep_if.sv
// Board-side signal bundle of the multi-key beeper. The slave modport is the
// controller's view; the master modport is the board/environment view.
interface multi_key_beep_if #(
  parameter int unsigned NUM_KEYS = 4
);
  logic [NUM_KEYS-1:0] key;
  logic [NUM_KEYS-1:0] key_value;
  logic [NUM_KEYS-1:0] key_flag;
  logic                beep;
  logic                beep_busy;

  modport master (
    output key,
    input  key_value,
    input  key_flag,
    input  beep,
    input  beep_busy
  );

  modport slave (
    input  key,
    output key_value,
    output key_flag,
    output beep,
    output beep_busy
  );
endinterface

// File: rtl/key_debounce_ch.sv
// One key channel: 2-FF synchroniser on the raw pin, stability counter, and
// the debounced level with a one-cycle change flag.
module key_debounce_ch
  import multi_key_beep_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 1_000_000
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key_raw,
  output logic key_value,
  output logic key_flag
);
  localparam int unsigned     CntW   = cnt_width(DEBOUNCE_CYC);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYC - 1);

  logic            sync1;
  logic            sync2;
  logic [CntW-1:0] cnt;

  // Synchronise, then accept a new level once it has been stable long enough.
  // A change of the synced level always passes through "equal to key_value"
  // for a two-level signal, so clearing on equality also covers level changes.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      cnt       <= '0;
      key_value <= 1'b1;
      key_flag  <= 1'b0;
    end else begin
      sync1    <= key_raw;
      sync2    <= sync1;
      key_flag <= 1'b0;
      if (sync2 == key_value) begin
        cnt <= '0;
      end else if (cnt == CntMax) begin
        key_value <= sync2;
        key_flag  <= 1'b1;
        cnt       <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/multi_key_beep.sv
// Multi-key beeper top: NUM_KEYS debounced active-low keys; key k pressed
// triggers a burst of k+1 beeps on a single buzzer output.
// Optional feature macro: MULTI_KEY_BEEP_TONE_EN (passive buzzer tone in ON).
module multi_key_beep
  import multi_key_beep_pkg::*;
#(
  parameter int unsigned NUM_KEYS      = 4,
  parameter int unsigned DEBOUNCE_CYC  = 1_000_000,
  parameter int unsigned BEEP_ON_CYC   = 5_000_000,
  parameter int unsigned BEEP_OFF_CYC  = 5_000_000,
  parameter int unsigned TONE_HALF_CYC = 12_500
) (
  input logic             sys_clk,
  input logic             sys_rst,
  multi_key_beep_if.slave kb
);
  localparam int unsigned    RemW    = cnt_width(NUM_KEYS);
  localparam int unsigned    PhMax   = (BEEP_ON_CYC > BEEP_OFF_CYC) ? BEEP_ON_CYC : BEEP_OFF_CYC;
  localparam int unsigned    PhW     = cnt_width(PhMax);
  localparam logic [PhW-1:0] OnLast  = PhW'(BEEP_ON_CYC - 1);
  localparam logic [PhW-1:0] OffLast = PhW'(BEEP_OFF_CYC - 1);

  logic [NUM_KEYS-1:0] key_value_w;
  logic [NUM_KEYS-1:0] key_flag_w;
  logic [NUM_KEYS-1:0] press;
  logic [RemW-1:0]     press_idx;

  beep_state_e     state;
  logic [RemW-1:0] remaining;
  logic [PhW-1:0]  phase_cnt;
  logic            beep_reg;
  logic            busy_reg;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_ch (
      .sys_clk  (sys_clk),
      .sys_rst  (sys_rst),
      .key_raw  (kb.key[i]),
      .key_value(key_value_w[i]),
      .key_flag (key_flag_w[i])
    );
  end

  assign kb.key_value = key_value_w;
  assign kb.key_flag  = key_flag_w;
  assign kb.beep      = beep_reg;
  assign kb.beep_busy = busy_reg;

  // Press events, lowest index wins.
  always_comb begin
    press     = key_flag_w & ~key_value_w;
    press_idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (press[i]) press_idx = RemW'(i);
    end
  end

`ifdef MULTI_KEY_BEEP_TONE_EN
  localparam int unsigned    ToneW    = cnt_width(TONE_HALF_CYC);
  localparam logic [ToneW-1:0] ToneLast = ToneW'(TONE_HALF_CYC - 1);
  logic [ToneW-1:0] tone_cnt;
`else
  logic unused_tone;
  assign unused_tone = ^TONE_HALF_CYC;
`endif

  // Burst FSM with registered beep/busy outputs.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= StIdle;
      remaining <= '0;
      phase_cnt <= '0;
      beep_reg  <= 1'b0;
      busy_reg  <= 1'b0;
`ifdef MULTI_KEY_BEEP_TONE_EN
      tone_cnt  <= '0;
`endif
    end else begin
      case (state)
        StIdle: begin
          if (|press) begin
            state     <= StOn;
            remaining <= press_idx;
            phase_cnt <= '0;
            beep_reg  <= 1'b1;
            busy_reg  <= 1'b1;
`ifdef MULTI_KEY_BEEP_TONE_EN
            tone_cnt  <= '0;
`endif
          end
        end
        StOn: begin
          if (phase_cnt == OnLast) begin
            state     <= StOff;
            phase_cnt <= '0;
            beep_reg  <= 1'b0;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
`ifdef MULTI_KEY_BEEP_TONE_EN
            if (tone_cnt == ToneLast) begin
              tone_cnt <= '0;
              beep_reg <= ~beep_reg;
            end else begin
              tone_cnt <= tone_cnt + 1'b1;
            end
`endif
          end
        end
        StOff: begin
          if (phase_cnt == OffLast) begin
            phase_cnt <= '0;
            if (remaining == '0) begin
              state    <= StIdle;
              busy_reg <= 1'b0;
            end else begin
              remaining <= remaining - 1'b1;
              state     <= StOn;
              beep_reg  <= 1'b1;
`ifdef MULTI_KEY_BEEP_TONE_EN
              tone_cnt  <= '0;
`endif
            end
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        default: begin
          state    <= StIdle;
          beep_reg <= 1'b0;
          busy_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule
